alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command front-end for the registered 16-bit ALU; sits directly upstream of it and owns its operand/opcode inputs and its result/flag outputs.
- Accepts tagged operation requests over a valid/ready handshake and buffers them in a command FIFO.
- Issues at most one operation per cycle to the ALU, tracks the ALU's one-cycle registered latency, and returns each result with its flags and tag, in order, over a valid/ready response interface.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- RSP_DEPTH, 4, response buffer entries; power of 2, minimum 4, which sustains one op per cycle.
- TAG_W, 4, width of the request tag.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when valid&ready at posedge.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_fun  in  4  ALU opcode, ALU encoding (0000 add .. 1110 shl, 1111 idle).
- cmd_tag  in  TAG_W  request tag, returned with result.
- alu_a  out  16  registered operand A to ALU.
- alu_b  out  16  registered operand B to ALU.
- alu_fun  out  4  registered opcode to ALU.
- alu_out  in  16  ALU result.
- alu_flags  in  5  {carry, arith, logic, cmp, shift} from ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_data  out  16  result.
- rsp_flags  out  5  flags, same order as alu_flags.
- rsp_tag  out  TAG_W  tag of the originating request.
- rsp_err  out  1  error marker; driven 0 unless DIV0_GUARD_EN.

Behaviour:
- Reset (async assert, sync deassert handled by the top level) clears state as follows:
  - FIFOs empty.
  - In-flight pipe cleared.
  - alu_a = alu_b = 0, alu_fun = 4'b1111.
  - rsp_valid = 0, rsp_data = 0, rsp_flags = 0, rsp_tag = 0, rsp_err = 0.
  - cmd_ready = 1 one cycle after deassert, with no stale output state.
- Reset mid-operation discards all queued and in-flight ops; no responses are produced for them.
- Command FIFO:
  - cmd_ready = !cmd_full; registered-state derived, with no combinational path from rsp_ready.
  - Push on cmd_valid&cmd_ready.
  - Read/write pointers wrap modulo CMD_DEPTH, with an extra wrap bit for full/empty.
  - Push and pop in the same cycle are legal whenever not full; count is unchanged.
- Issue (stage S0):
  - Condition: FIFO non-empty AND (rsp_count + inflight) < RSP_DEPTH, where inflight is the number of valid bits in S1/S2.
  - On issue, at the posedge: pop the head; load alu_a/alu_b/alu_fun; set S1 valid with the tag.
  - No issue: alu_fun = 4'b1111, alu_a/alu_b hold; S1 valid = 0.
- Pipeline:
  - S1 models the ALU register (ALU samples alu_* at the next edge); S1 advances to S2 every cycle unconditionally.
  - When S2 is valid, alu_out/alu_flags are captured into the response buffer with the S2 tag.
  - The credit rule guarantees space, so capture never stalls; overflow is a design error and carries an assertion.
- Response buffer:
  - FIFO of depth RSP_DEPTH; the head drives rsp_*.
  - Pop on rsp_valid&rsp_ready.
  - rsp_* are stable while rsp_valid&!rsp_ready.
  - Credit does not count a same-cycle pop (conservative).
- Latency: request accepted at edge E (FIFO empty, credits available) -> alu_* loaded at E+1 -> ALU result at E+2 -> rsp_valid at E+3.
- Throughput: 1 op/cycle sustained with rsp_ready=1 and RSP_DEPTH>=4.
- Ordering: strict FIFO order; tags are opaque and not checked for uniqueness.
- Backpressure: with rsp_ready=0, exactly RSP_DEPTH results are buffered, then issue stops. The command FIFO then fills and cmd_ready drops after CMD_DEPTH further accepts.

Optional Feature:
- Macro: ALU_SEQ_DIV0_GUARD_EN.
- Defined: an op with cmd_fun=4'b0011 and cmd_b=0 still consumes an issue slot and credit, but alu_fun is driven 4'b1111. On capture, that entry is replaced with rsp_data=16'hFFFF, rsp_flags=5'b01000 (arith), rsp_err=1. Timing and ordering are identical to a normal op.
- Undefined: no special case; divide-by-zero passes to the ALU unchanged; rsp_err tied 0.

Test Plan:
- Single op: reset, then push add A=16'h0003 B=16'h0004 tag=1 -> rsp_valid exactly 3 cycles after accept; data=16'h0007, flags=5'b01000, tag=1.
- Carry and back-to-back: push add FFFF+0001 then sub 0005-0003 consecutively, rsp_ready=1 -> consecutive responses: data=0000 flags=11000, then data=0002 flags=01000; no bubble.
- Backpressure: rsp_ready=0, push 10 ops -> 4 buffered, cmd_ready falls after 4 more accepts. Raise rsp_ready -> all 8 accepted ops (4 buffered, 4 queued) return in order; the remaining 2 are accepted once cmd_ready rises and also return in order; tags match.
- Compare/shift: cmp-gt A=9 B=2 -> data=0002 flags=00010; shl A=8001 -> data=0002 flags=00001.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight and 2 queued -> all rsp_* zero and alu_fun=1111 immediately (async). After release: no stale responses; a new op returns with normal latency.
- Divide by zero with ALU_SEQ_DIV0_GUARD_EN: div A=10 B=0 -> alu_fun seen as 1111, rsp_data=FFFF, rsp_err=1. Without the macro -> alu_fun=0011, rsp_err=0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: request, response and ALU-side signals of the ALU command sequencer
interface alu_cmd_sequencer_if #(parameter int TAG_W = 4);
  logic             cmd_valid, cmd_ready;
  logic [15:0]      cmd_a, cmd_b;
  logic [3:0]       cmd_fun;
  logic [TAG_W-1:0] cmd_tag;
  logic [15:0]      alu_a, alu_b, alu_out;
  logic [3:0]       alu_fun;
  logic [4:0]       alu_flags;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [15:0]      rsp_data;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag, alu_out, alu_flags, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag, alu_out, alu_flags, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers tagged ALU requests, issues them to the registered ALU and returns results in order
// Optional divide-by-zero guard enabled by defining ALU_SEQ_DIV0_GUARD_EN
module alu_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [3:0]       fun;
    logic [TAG_W-1:0] tag;
  } cmd_t;
  typedef struct packed {
    logic [15:0]      data;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;
  cmd_t             cmd_mem_q [CMD_DEPTH];
  rsp_t             rsp_mem_q [RSP_DEPTH];
  logic [CAW:0]     cmd_wr_q, cmd_rd_q;
  logic [RAW:0]     rsp_wr_q, rsp_rd_q, rsp_cnt;
  logic             s1_v_q, s2_v_q, s1_err_q, s2_err_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [15:0]      alu_a_q, alu_b_q;
  logic [3:0]       alu_fun_q;
  logic             cmd_full, cmd_empty, rsp_full, push, issue, rsp_pop, div0;
  cmd_t             head;
  rsp_t             cap;
  assign head      = cmd_mem_q[cmd_rd_q[CAW-1:0]];
  assign cmd_empty = cmd_wr_q == cmd_rd_q;
  assign cmd_full  = cmd_wr_q == {~cmd_rd_q[CAW], cmd_rd_q[CAW-1:0]};
  assign rsp_cnt   = rsp_wr_q - rsp_rd_q;
  assign rsp_full  = rsp_cnt[RAW];
  assign push      = bus.cmd_valid && !cmd_full;
  assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;
  // Credits ignore a same-cycle response pop, so a captured result always finds room
  assign issue     = !cmd_empty && (int'(rsp_cnt) + int'(s1_v_q) + int'(s2_v_q) < RSP_DEPTH);
`ifdef ALU_SEQ_DIV0_GUARD_EN
  assign div0 = head.fun == 4'b0011 && head.b == 16'h0000;
`else
  assign div0 = 1'b0;
`endif
  assign cap = s2_err_q ? rsp_t'{16'hFFFF, 5'b01000, s2_tag_q, 1'b1}
                        : rsp_t'{bus.alu_out, bus.alu_flags, s2_tag_q, 1'b0};
  assign bus.cmd_ready = !cmd_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.rsp_valid = rsp_wr_q != rsp_rd_q;
  assign {bus.rsp_data, bus.rsp_flags, bus.rsp_tag, bus.rsp_err} = rsp_mem_q[rsp_rd_q[RAW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_mem_q[i] <= '0;
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_err_q  <= 1'b0;
      s2_err_q  <= 1'b0;
      s1_tag_q  <= '0;
      s2_tag_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= 4'hF;
    end else begin
      if (push) begin
        cmd_mem_q[cmd_wr_q[CAW-1:0]] <= cmd_t'{bus.cmd_a, bus.cmd_b, bus.cmd_fun, bus.cmd_tag};
        cmd_wr_q <= cmd_wr_q + (CAW+1)'(1);
      end
      if (issue) begin
        cmd_rd_q <= cmd_rd_q + (CAW+1)'(1);
        alu_a_q  <= head.a;
        alu_b_q  <= head.b;
      end
      alu_fun_q <= issue && !div0 ? head.fun : 4'hF;
      s1_v_q    <= issue;
      s1_tag_q  <= head.tag;
      s1_err_q  <= issue && div0;
      s2_v_q    <= s1_v_q;
      s2_tag_q  <= s1_tag_q;
      s2_err_q  <= s1_err_q;
      if (s2_v_q) begin
        rsp_mem_q[rsp_wr_q[RAW-1:0]] <= cap;
        rsp_wr_q <= rsp_wr_q + (RAW+1)'(1);
      end
      if (rsp_pop) rsp_rd_q <= rsp_rd_q + (RAW+1)'(1);
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(s2_v_q && rsp_full));
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed tests of alu_cmd_sequencer against a small registered ALU model
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  alu_cmd_sequencer_if #(.TAG_W(4)) bus();
  alu_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // ALU: 0000 add, 0001 sub, 0011 div, 1000 cmp-gt, 1110 shl, 1111 idle; returns {flags, result}
  function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    s = '0;
    case (f)
      4'b0000: begin s = {1'b0, a} + {1'b0, b}; return {s[16], 4'b1000, s[15:0]}; end
      4'b0001: begin s = {1'b0, a} - {1'b0, b}; return {s[16], 4'b1000, s[15:0]}; end
      4'b0011: return {5'b01000, (b == 16'h0) ? 16'h0000 : a / b};
      4'b1000: return {5'b00010, (a > b) ? 16'h0002 : 16'h0000};
      4'b1110: return {5'b00001, a[14:0], 1'b0};
      default: return '0;
    endcase
  endfunction
  always @(posedge clk) {bus.alu_flags, bus.alu_out} <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input logic [3:0] t, input int budget, output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_fun = f;
    bus.cmd_tag = t;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = '0; bus.cmd_tag = '0;
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.alu_fun !== 4'hF) begin errors++; $display("FAIL reset_alu_fun got=%h exp=f", bus.alu_fun); end
    checks++; if (bus.alu_a !== 16'h0) begin errors++; $display("FAIL reset_alu_a got=%h exp=0", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0) begin errors++; $display("FAIL reset_alu_b got=%h exp=0", bus.alu_b); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_flags !== 5'h0) begin errors++; $display("FAIL reset_rsp_flags got=%b exp=0", bus.rsp_flags); end
    checks++; if (bus.rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_rsp_tag got=%h exp=0", bus.rsp_tag); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_single;
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    push_op(16'h0003, 16'h0004, 4'b0000, 4'h1, 5, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", ok); end
    wait_rsp(10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", n); end
    checks++; if (bus.rsp_data !== 16'h0007) begin errors++; $display("FAIL single_data got=%h exp=0007", bus.rsp_data); end
    checks++; if (bus.rsp_flags !== 5'b01000) begin errors++; $display("FAIL single_flags got=%b exp=01000", bus.rsp_flags); end
    checks++; if (bus.rsp_tag !== 4'h1) begin errors++; $display("FAIL single_tag got=%h exp=1", bus.rsp_tag); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    push_op(16'hFFFF, 16'h0001, 4'b0000, 4'h2, 5, ok);
    push_op(16'h0005, 16'h0003, 4'b0001, 4'h3, 5, ok);
    wait_rsp(10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", n); end
    checks++; if (bus.rsp_data !== 16'h0000 || bus.rsp_flags !== 5'b11000 || bus.rsp_tag !== 4'h2) begin
      errors++; $display("FAIL b2b_first got=%h/%b/%h exp=0000/11000/2", bus.rsp_data, bus.rsp_flags, bus.rsp_tag); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0002 || bus.rsp_flags !== 5'b01000 || bus.rsp_tag !== 4'h3) begin
      errors++; $display("FAIL b2b_second got=%h/%b/%h exp=0002/01000/3", bus.rsp_data, bus.rsp_flags, bus.rsp_tag); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int acc;
    int got;
    logic [15:0] exp;
    acc = 0;
    got = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_op(16'(i * 257), 16'h0010, 4'b0000, 4'(i), 3, ok);
      if (!ok) break;
      acc++;
    end
    checks++; if (acc !== 8) begin errors++; $display("FAIL bp_accepted got=%0d exp=8", acc); end
    repeat (4) tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if (bus.alu_fun !== 4'hF) begin errors++; $display("FAIL bp_issue_stopped got=%h exp=f", bus.alu_fun); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'h0 || bus.rsp_data !== 16'h0010) begin
      errors++; $display("FAIL bp_hold got=%b/%h/%h exp=1/0/0010", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    fork
      begin
        for (int i = 8; i < 10; i++) begin
          push_op(16'(i * 257), 16'h0010, 4'b0000, 4'(i), 40, ok);
          checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_late_accept op=%0d got=%b exp=1", i, ok); end
        end
      end
      begin
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 80 && got < 10; n++) begin
          if (bus.rsp_valid) begin
            exp = 16'(got * 257 + 16);
            checks++;
            if (bus.rsp_tag !== 4'(got) || bus.rsp_data !== exp || bus.rsp_flags !== 5'b01000) begin
              errors++;
              $display("FAIL bp_order idx=%0d got=%h/%h/%b exp=%h/%h/01000", got, bus.rsp_tag, bus.rsp_data,
                       bus.rsp_flags, 4'(got), exp);
            end
            got++;
          end
          tick();
        end
      end
    join
    checks++; if (got !== 10) begin errors++; $display("FAIL bp_count got=%0d exp=10", got); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_cmp_shift;
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    push_op(16'h0009, 16'h0002, 4'b1000, 4'h5, 5, ok);
    push_op(16'h8001, 16'h0000, 4'b1110, 4'h6, 5, ok);
    wait_rsp(10, n);
    checks++; if (bus.rsp_data !== 16'h0002 || bus.rsp_flags !== 5'b00010 || bus.rsp_tag !== 4'h5) begin
      errors++; $display("FAIL cmp_gt got=%h/%b/%h exp=0002/00010/5", bus.rsp_data, bus.rsp_flags, bus.rsp_tag); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0002 || bus.rsp_flags !== 5'b00001 || bus.rsp_tag !== 4'h6) begin
      errors++; $display("FAIL shl got=%b/%h/%b/%h exp=1/0002/00001/6", bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_tag); end
    tick();
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    int seen;
    seen = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(16'(i + 1), 16'(i + 1), 4'b0000, 4'(10 + i), 5, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0 || bus.rsp_flags !== 5'h0 || bus.rsp_tag !== 4'h0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL mid_rsp_fields got=%h/%b/%h/%b exp=0/0/0/0", bus.rsp_data, bus.rsp_flags, bus.rsp_tag, bus.rsp_err); end
    checks++; if (bus.alu_fun !== 4'hF) begin errors++; $display("FAIL mid_alu_fun got=%h exp=f", bus.alu_fun); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", seen); end
    push_op(16'h0001, 16'h0002, 4'b0000, 4'h9, 5, ok);
    wait_rsp(10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL mid_latency got=%0d exp=3", n); end
    checks++; if (bus.rsp_data !== 16'h0003 || bus.rsp_tag !== 4'h9) begin
      errors++; $display("FAIL mid_new_op got=%h/%h exp=0003/9", bus.rsp_data, bus.rsp_tag); end
    tick();
  endtask

  task automatic test_div0;
    bit ok;
    int n;
    logic [3:0] exp_fun;
    logic [15:0] exp_data;
    logic exp_err;
`ifdef ALU_SEQ_DIV0_GUARD_EN
    exp_fun = 4'hF; exp_data = 16'hFFFF; exp_err = 1'b1;
`else
    exp_fun = 4'h3; exp_data = 16'h0000; exp_err = 1'b0;
`endif
    bus.rsp_ready = 1'b1;
    push_op(16'h000A, 16'h0000, 4'b0011, 4'h7, 5, ok);
    tick();
    checks++; if (bus.alu_fun !== exp_fun) begin errors++; $display("FAIL div0_alu_fun got=%h exp=%h", bus.alu_fun, exp_fun); end
    wait_rsp(10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL div0_latency got=%0d exp=2", n); end
    checks++; if (bus.rsp_data !== exp_data || bus.rsp_err !== exp_err) begin
      errors++; $display("FAIL div0_rsp got=%h/%b exp=%h/%b", bus.rsp_data, bus.rsp_err, exp_data, exp_err); end
    checks++; if (bus.rsp_flags !== 5'b01000 || bus.rsp_tag !== 4'h7) begin
      errors++; $display("FAIL div0_flags_tag got=%b/%h exp=01000/7", bus.rsp_flags, bus.rsp_tag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_cmp_shift();
    test_reset_mid();
    test_div0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
